// File: rtl/hram_wb_arbiter.sv
// Round-robin Wishbone B4 arbiter sharing the HyperRAM data port between NUM_M masters,
// with a per-grant burst cap and a slave stall watchdog.
module hram_wb_arbiter #(
    parameter int unsigned NUM_M       = 3,
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned MAX_BEATS   = 64,
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic [NUM_M*AW-1:0]     m_adr_i,
    input  logic [NUM_M*DW-1:0]     m_dat_i,
    input  logic [NUM_M*DW/8-1:0]   m_sel_i,
    input  logic [NUM_M*3-1:0]      m_cti_i,
    input  logic [NUM_M-1:0]        m_we_i,
    input  logic [NUM_M-1:0]        m_cyc_i,
    input  logic [NUM_M-1:0]        m_stb_i,
    output logic [DW-1:0]           m_dat_o,
    output logic [NUM_M-1:0]        m_ack_o,
    output logic [NUM_M-1:0]        m_err_o,
    output logic [AW-1:0]           s_adr_o,
    output logic [DW-1:0]           s_dat_o,
    output logic [DW/8-1:0]         s_sel_o,
    output logic [2:0]              s_cti_o,
    output logic                    s_we_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    input  logic [DW-1:0]           s_dat_i,
    input  logic                    s_ack_i,
    output logic [NUM_M-1:0]        grant_o
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int unsigned BW = $clog2(MAX_BEATS + 1);
    localparam int unsigned WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

    localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BEATS - 1);
    localparam logic [BW-1:0] BEAT_SAT  = BW'(MAX_BEATS);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);
    localparam logic [2:0]    CTI_INCR  = 3'b010;
    localparam logic [2:0]    CTI_EOB   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_RELEASE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   gnt_idx_q, gnt_idx_d;
    logic [NUM_M-1:0] grant_q, grant_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [WW-1:0]   wdog_q, wdog_d;

    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic [AW-1:0]   g_adr;
    logic [DW-1:0]   g_dat;
    logic [SW-1:0]   g_sel;
    logic [2:0]      g_cti;
    logic            g_we;
    logic            g_cyc;
    logic            g_stb;
    logic            wdog_expire;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_M) s = s - NUM_M;
        return IW'(s);
    endfunction

    // First requester at or after the round-robin pointer; lowest offset wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int unsigned k = NUM_M; k > 0; k--) begin
            if (m_cyc_i[wrap_add(ptr_q, k - 1)]) begin
                pick_vld = 1'b1;
                pick_idx = wrap_add(ptr_q, k - 1);
            end
        end
    end

    always_comb begin
        g_adr = m_adr_i[32'(gnt_idx_q) * AW +: AW];
        g_dat = m_dat_i[32'(gnt_idx_q) * DW +: DW];
        g_sel = m_sel_i[32'(gnt_idx_q) * SW +: SW];
        g_cti = m_cti_i[32'(gnt_idx_q) * 3 +: 3];
        g_we  = m_we_i[gnt_idx_q];
        g_cyc = m_cyc_i[gnt_idx_q];
        g_stb = m_stb_i[gnt_idx_q];
    end

    // A same-cycle ack beats the watchdog, so expiry needs the ack to be absent.
    assign wdog_expire = (state_q == ST_ACTIVE) && g_cyc && g_stb &&
                         (wdog_q == WDOG_LAST) && !s_ack_i;

    assign m_dat_o = s_dat_i;
    assign grant_o = grant_q;

    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        beat_d    = beat_q;
        wdog_d    = wdog_q;
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        s_cti_o   = '0;
        s_we_o    = 1'b0;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        m_ack_o   = '0;
        m_err_o   = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d   = ST_ACTIVE;
                    gnt_idx_d = pick_idx;
                    grant_d   = NUM_M'(1'b1) << pick_idx;
                    beat_d    = '0;
                    wdog_d    = '0;
                end
            end

            ST_ACTIVE: begin
                s_adr_o = g_adr;
                s_dat_o = g_dat;
                s_sel_o = g_sel;
                s_we_o  = g_we;
                s_cyc_o = g_cyc;
                s_stb_o = g_stb && !wdog_expire;
                s_cti_o = ((beat_q == BEAT_LAST) && (g_cti == CTI_INCR)) ? CTI_EOB : g_cti;
                m_ack_o[gnt_idx_q] = s_ack_i;
                m_err_o[gnt_idx_q] = wdog_expire;

                if (s_ack_i) begin
                    wdog_d = '0;
                    if (beat_q != BEAT_SAT) beat_d = BW'(beat_q + 1'b1);
                end else if (g_stb && !wdog_expire) begin
                    wdog_d = WW'(wdog_q + 1'b1);
                end

                if (!g_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = wrap_add(gnt_idx_q, 1);
                end else if ((s_ack_i && (beat_q == BEAT_LAST)) || wdog_expire) begin
                    state_d = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                state_d = ST_IDLE;
                grant_d = '0;
                ptr_d   = wrap_add(gnt_idx_q, 1);
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            gnt_idx_q <= '0;
            grant_q   <= '0;
            ptr_q     <= '0;
            beat_q    <= '0;
            wdog_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            beat_q    <= beat_d;
            wdog_q    <= wdog_d;
        end
    end

endmodule

// File: tb/tb_hram_wb_arbiter.sv
// Randomized bench for hram_wb_arbiter: master/slave traffic generators, a bus-ownership
// reference model checked every cycle, and a memory scoreboard for read data.
module tb_hram_wb_arbiter;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MB = 64;
    localparam int WD = 16;

    logic              clk;
    logic              rst;
    logic [NM*AW-1:0]  m_adr;
    logic [NM*DW-1:0]  m_dat;
    logic [NM*4-1:0]   m_sel;
    logic [NM*3-1:0]   m_cti;
    logic [NM-1:0]     m_we, m_cyc, m_stb;
    logic [DW-1:0]     m_dat_o;
    logic [NM-1:0]     m_ack, m_err;
    logic [AW-1:0]     s_adr;
    logic [DW-1:0]     s_dat_o, s_dat_i;
    logic [3:0]        s_sel;
    logic [2:0]        s_cti;
    logic              s_we, s_cyc, s_stb, s_ack;
    logic [NM-1:0]     grant;

    hram_wb_arbiter #(
        .NUM_M(NM), .AW(AW), .DW(DW), .MAX_BEATS(MB), .WDOG_CYCLES(WD)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_cti_i(m_cti),
        .m_we_i(m_we), .m_cyc_i(m_cyc), .m_stb_i(m_stb),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack), .m_err_o(m_err),
        .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_sel_o(s_sel), .s_cti_o(s_cti),
        .s_we_o(s_we), .s_cyc_o(s_cyc), .s_stb_o(s_stb),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack), .grant_o(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memories: what the slave holds, and what the masters believe it holds.
    logic [31:0] smem   [logic [31:0]];
    logic [31:0] refmem [logic [31:0]];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'h3C3C_A5A5;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] s_rd(input logic [31:0] a);
        return smem.exists(a) ? smem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return refmem.exists(a) ? refmem[a] : init_val(a);
    endfunction

    // Master traffic generators.
    int          left [NM];
    logic [31:0] adr [NM];
    logic [31:0] wdat [NM];
    logic [3:0]  sel [NM];
    bit          we [NM];
    bit          burst [NM];
    int          done_beats [NM];
    int          errs [NM];
    int          err_hi [NM];
    logic [31:0] last_rdata [NM];
    bit          rnd_en = 0;
    bit          rr_en = 0;

    task automatic start_job(input int i, input int beats, input bit w, input logic [31:0] a);
        left[i]  = beats;
        burst[i] = (beats > 1);
        we[i]    = w;
        adr[i]   = a;
        wdat[i]  = $urandom;
        sel[i]   = 4'($urandom_range(1, 15));
    endtask

    task automatic drive_masters();
        for (int i = 0; i < NM; i++) begin
            if (left[i] == 0 && !m_cyc[i] && rr_en)
                start_job(i, 1, 1'b0, 32'(i << 16));
            if (left[i] == 0 && !m_cyc[i] && rnd_en && $urandom_range(0, 2) == 0)
                start_job(i, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 8)) : 1,
                          1'($urandom_range(0, 1)), 32'(i << 16) | 32'($urandom_range(0, 31) << 2));
            if (left[i] > 0) begin
                m_cyc[i] = 1'b1;
                m_stb[i] = 1'b1;
                m_we[i]  = we[i];
                m_adr[i*AW +: AW] = adr[i];
                m_dat[i*DW +: DW] = wdat[i];
                m_sel[i*4 +: 4]   = sel[i];
                m_cti[i*3 +: 3]   = burst[i] ? ((left[i] == 1) ? 3'b111 : 3'b010) : 3'b000;
            end else begin
                m_cyc[i] = 1'b0;
                m_stb[i] = 1'b0;
                m_we[i]  = 1'($urandom);
                m_adr[i*AW +: AW] = $urandom;
                m_dat[i*DW +: DW] = $urandom;
                m_sel[i*4 +: 4]   = 4'($urandom);
                m_cti[i*3 +: 3]   = 3'($urandom);
            end
        end
    endtask

    task automatic observe_masters();
        for (int i = 0; i < NM; i++) begin
            if (m_ack[i] && left[i] > 0) begin
                if (we[i]) refmem[adr[i]] = merge(ref_rd(adr[i]), wdat[i], sel[i]);
                else begin
                    last_rdata[i] = m_dat_o;
                    chk("rdata", m_dat_o, ref_rd(adr[i]));
                end
                left[i]--;
                adr[i] = adr[i] + 32'd4;
                done_beats[i]++;
                wdat[i] = $urandom;
                sel[i]  = 4'($urandom_range(1, 15));
            end
            if (m_err[i]) begin
                err_hi[i]++;
                if (left[i] > 0) begin
                    errs[i]++;
                    left[i] = 0;
                end
            end
        end
    endtask

    // Slave: acks after cur_lat stalled cycles of s_cyc_o; mode 0 random, 1 fixed, 2 never.
    int slat_mode = 0;
    int slat_fix = 0;
    int cur_lat = 0;
    int scnt = 0;

    function automatic int pick_lat();
        if (slat_mode == 1) return slat_fix;
        return ($urandom_range(0, 9) == 0) ? int'($urandom_range(12, 20)) : int'($urandom_range(0, 3));
    endfunction

    task automatic set_slave(input int mode, input int lat);
        slat_mode = mode;
        slat_fix  = lat;
        cur_lat   = pick_lat();
    endtask

    task automatic drive_slave();
        if (s_cyc && slat_mode != 2 && scnt >= cur_lat) begin
            s_ack = 1'b1;
            if (s_we) begin
                smem[s_adr] = merge(s_rd(s_adr), s_dat_o, s_sel);
                s_dat_i = $urandom;
            end else begin
                s_dat_i = s_rd(s_adr);
            end
            scnt = 0;
            cur_lat = pick_lat();
        end else begin
            s_ack = 1'b0;
            s_dat_i = $urandom;
            scnt = s_cyc ? scnt + 1 : 0;
        end
    endtask

    // Reference model of bus ownership: owner (-1 when nobody), releasing flag,
    // round-robin start point, acked beats and stalled strobe cycles of this grant.
    int own = -1, ptr = 0, beats = 0, stall = 0;
    bit rel = 0;
    int n_own, n_ptr, n_beats, n_stall;
    bit n_rel;

    task automatic model_step();
        logic [NM-1:0] e_grant, e_ack, e_err;
        logic e_cyc, e_stb, mstb, expire;
        logic [2:0] e_cti, mcti;
        e_grant = '0; e_ack = '0; e_err = '0;
        e_cyc = 1'b0; e_stb = 1'b0; e_cti = 3'b000; expire = 1'b0;
        n_own = own; n_ptr = ptr; n_beats = beats; n_stall = stall; n_rel = rel;
        if (own >= 0) e_grant[own] = 1'b1;
        if (own >= 0 && !rel) begin
            e_cyc  = m_cyc[own];
            mstb   = m_stb[own];
            mcti   = m_cti[own*3 +: 3];
            expire = e_cyc && mstb && (stall == WD - 1) && !s_ack;
            e_stb  = mstb && !expire;
            e_cti  = (beats == MB - 1 && mcti == 3'b010) ? 3'b111 : mcti;
            e_ack[own] = s_ack;
            e_err[own] = expire;
            chk("s_adr", s_adr, m_adr[own*AW +: AW]);
            chk("s_dat", s_dat_o, m_dat[own*DW +: DW]);
            chk("s_sel", 32'(s_sel), 32'(m_sel[own*4 +: 4]));
            chk("s_we", 32'(s_we), 32'(m_we[own]));
        end
        chk("grant", 32'(grant), 32'(e_grant));
        chk("s_cyc", 32'(s_cyc), 32'(e_cyc));
        chk("s_stb", 32'(s_stb), 32'(e_stb));
        chk("s_cti", 32'(s_cti), 32'(e_cti));
        chk("m_ack", 32'(m_ack), 32'(e_ack));
        chk("m_err", 32'(m_err), 32'(e_err));
        chk("m_dat", m_dat_o, s_dat_i);

        if (rst) begin
            n_own = -1; n_rel = 0; n_ptr = 0;
        end else if (own < 0) begin
            for (int k = 0; k < NM; k++) begin
                if (n_own < 0 && m_cyc[(ptr + k) % NM]) begin
                    n_own = (ptr + k) % NM;
                    n_beats = 0;
                    n_stall = 0;
                end
            end
        end else if (rel || !e_cyc) begin
            n_own = -1; n_rel = 0; n_ptr = (own + 1) % NM;
        end else begin
            if (s_ack) begin
                n_stall = 0;
                n_beats = (beats < MB) ? beats + 1 : beats;
            end else if (e_stb) begin
                n_stall = stall + 1;
            end
            if ((s_ack && beats == MB - 1) || expire) n_rel = 1;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step();
        observe_masters();
        @(posedge clk);
        own = n_own; ptr = n_ptr; beats = n_beats; stall = n_stall; rel = n_rel;
        #1;
        drive_masters();
        #1;
        drive_slave();
    endtask

    function automatic bit busy();
        bit b;
        b = (grant != '0) || (m_cyc != '0);
        for (int i = 0; i < NM; i++) if (left[i] > 0) b = 1;
        return b;
    endfunction

    task automatic drain(input string tag, input int bound);
        for (int n = 0; n < bound && busy(); n++) cycle();
        chk(tag, 32'(busy()), 32'd0);
    endtask

    function automatic int oh_idx(input logic [NM-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NM; i++) if (v[i]) r = i;
        return r;
    endfunction

    int d0, b2, d1, e1, h1, cap, ng, last, zrun, idx;
    bit m1_go;
    logic [NM-1:0] prevg;

    initial begin
        rst = 1'b1;
        m_adr = '0; m_dat = '0; m_sel = '0; m_cti = '0;
        m_we = '0; m_cyc = '0; m_stb = '0;
        s_ack = 1'b0; s_dat_i = '0;
        for (int i = 0; i < NM; i++) begin
            left[i] = 0; adr[i] = '0; wdat[i] = '0; sel[i] = '0; we[i] = 0; burst[i] = 0;
            done_beats[i] = 0; errs[i] = 0; err_hi[i] = 0; last_rdata[i] = '0;
        end
        repeat (2) @(posedge clk);
        #2;
        cycle();
        cycle();
        rst = 1'b0;

        // Single classic read by master 0.
        set_slave(1, 3);
        smem[32'h100] = 32'hDEAD_BEEF;
        refmem[32'h100] = 32'hDEAD_BEEF;
        start_job(0, 1, 1'b0, 32'h100);
        d0 = done_beats[0];
        for (int n = 0; n < 40 && done_beats[0] == d0; n++) cycle();
        chk("single_done", 32'(done_beats[0] - d0), 32'd1);
        chk("single_rd", last_rdata[0], 32'hDEAD_BEEF);
        drain("to_single", 20);

        // All masters requesting single beats: strict rotation with one idle cycle between.
        set_slave(1, 0);
        rr_en = 1;
        prevg = grant; zrun = 0; ng = 0; last = -1;
        for (int n = 0; n < 200 && ng < 12; n++) begin
            cycle();
            if (grant == '0) zrun++;
            else if (prevg == '0) begin
                idx = oh_idx(grant);
                if (last >= 0) begin
                    chk("rr_order", 32'(idx), 32'((last + 1) % NM));
                    chk("rr_gap", 32'(zrun), 32'd1);
                end
                last = idx; ng++; zrun = 0;
            end
            prevg = grant;
        end
        chk("rr_grants", 32'(ng), 32'd12);
        rr_en = 0;
        drain("to_rr", 50);

        // 100-beat burst from master 2 is cut at 64 beats so master 1 gets in.
        set_slave(1, 0);
        start_job(2, 100, 1'b0, 32'h2_0000);
        b2 = done_beats[2]; d1 = done_beats[1]; m1_go = 0; cap = -1;
        for (int n = 0; n < 400 && done_beats[2] - b2 < 100; n++) begin
            cycle();
            if (!m1_go && done_beats[2] - b2 >= 10) begin
                start_job(1, 1, 1'b0, 32'h1_0010);
                m1_go = 1;
            end
            if (cap < 0 && done_beats[1] != d1) cap = done_beats[2] - b2;
        end
        chk("burst_done", 32'(done_beats[2] - b2), 32'd100);
        chk("cap_beats", 32'(cap), 32'd64);
        chk("m1_served", 32'(done_beats[1] - d1), 32'd1);
        drain("to_burst", 50);

        // Slave never acks master 1: one error pulse, then the bus is released.
        set_slave(2, 0);
        start_job(1, 1, 1'b0, 32'h1_0040);
        e1 = errs[1]; h1 = err_hi[1]; d1 = done_beats[1];
        for (int n = 0; n < 80 && errs[1] == e1; n++) cycle();
        chk("wdog_err", 32'(errs[1] - e1), 32'd1);
        cycle(); cycle(); cycle();
        chk("wdog_pulses", 32'(err_hi[1] - h1), 32'd1);
        chk("wdog_noack", 32'(done_beats[1] - d1), 32'd0);
        chk("wdog_grant", 32'(grant), 32'd0);
        chk("wdog_cyc", 32'(s_cyc), 32'd0);

        // Ack on the very cycle the watchdog would expire.
        set_slave(1, WD - 1);
        start_job(1, 1, 1'b0, 32'h1_0044);
        e1 = errs[1]; h1 = err_hi[1]; d1 = done_beats[1];
        for (int n = 0; n < 80 && done_beats[1] == d1; n++) cycle();
        chk("edge_done", 32'(done_beats[1] - d1), 32'd1);
        chk("edge_noerr", 32'(err_hi[1] - h1), 32'd0);
        drain("to_edge", 20);

        // Random traffic, a mid-transfer reset, more random traffic.
        set_slave(0, 0);
        rnd_en = 1;
        repeat (3000) cycle();
        for (int n = 0; n < 200 && !s_cyc; n++) cycle();
        chk("pre_rst_busy", 32'(s_cyc), 32'd1);
        rst = 1'b1;
        cycle();
        chk("rst_cyc", 32'(s_cyc), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        cycle();
        cycle();
        rst = 1'b0;
        repeat (1500) cycle();
        rnd_en = 0;
        drain("to_final", 2000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
